down_counter_timer: RTL

Loadable down-counting timer that is the counterpart of the team's free-running up counter: it is preloaded with a value, counts toward zero, and reports expiry. The block sits beside the up counter in the lab datapath and supplies timeouts and delay intervals to the other blocks. A small FSM sequences the block through idle, run and done states, with pause, restart and an optional auto-reload.

---
 rtl/timer_pkg.sv | 17 +
 rtl/down_counter_timer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the loadable down-counting timer.
//   timer_state_e : sequencing states of the timer FSM (IDLE, RUN, DONE)
//   TIMER_W       : default counter width in bits
// -----------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_e;

   localparam int TIMER_W = 4;

endpackage : timer_pkg

// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
// Loadable down-counting timer. A preloaded value counts toward zero while
// running; reaching zero reports expiry with a one-cycle tc pulse. A small
// FSM sequences IDLE -> RUN -> DONE with pause, restart from DONE and an
// optional auto-reload.
//
// Build option:
//   AUTO_RELOAD_EN  when defined, expiry reloads the count from the reload
//                   register and the timer keeps running (DONE never entered).
//                   When undefined, expiry parks the timer in DONE at count 0.
//
// Ports:
//   clk       in   clock, all state changes on its rising edge
//   rst       in   synchronous active-high reset, priority over everything
//   load      in   latch load_val into count and reload, return to IDLE
//   load_val  in   [W-1:0] value to load
//   start     in   begin counting (IDLE) or restart from reload (DONE)
//   pause     in   level, freezes the count while running
//   count     out  [W-1:0] current count, registered
//   busy      out  high while in RUN, registered
//   tc        out  terminal-count pulse, one cycle per expiry, registered
//   done      out  high while in DONE, registered
// -----------------------------------------------------------------------------
module down_counter_timer
   import timer_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         start,
   input  logic         pause,
   output logic [W-1:0] count,
   output logic         busy,
   output logic         tc,
   output logic         done
);

   localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
   localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

   timer_state_e state_r;
   timer_state_e state_nxt_s;

   logic [W-1:0] count_r;
   logic [W-1:0] reload_r;
   logic         tc_r;
   logic         busy_r;
   logic         done_r;

   logic [W-1:0] count_nxt_s;
   logic [W-1:0] reload_nxt_s;
   logic         tc_nxt_s;
   logic         busy_nxt_s;
   logic         done_nxt_s;
   logic         expire_s;

   // An unpaused decrement from 1 to 0 while running is the expiry edge.
   assign expire_s = (state_r == RUN) && !pause && (count_r == CNT_ONE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; load overrides start and pause in every state.
   always_comb begin
      state_nxt_s = state_r;
      if (load) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start && (count_r != CNT_ZERO)) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            RUN: begin
               if (expire_s) begin
`ifdef AUTO_RELOAD_EN
                  state_nxt_s = RUN;
`else
                  state_nxt_s = DONE;
`endif
               end else if (count_r == CNT_ZERO) begin
                  // Unreachable by construction; leave RUN rather than wrap.
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            DONE: begin
               // A restart with an empty reload value would expire instantly.
               if (start && (reload_r != CNT_ZERO)) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = DONE;
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // Output and datapath next values: count, reload, tc pulse, status flags.
   always_comb begin
      count_nxt_s  = count_r;
      reload_nxt_s = reload_r;
      tc_nxt_s     = 1'b0;
      busy_nxt_s   = (state_nxt_s == RUN);
      done_nxt_s   = (state_nxt_s == DONE);
      if (load) begin
         count_nxt_s  = load_val;
         reload_nxt_s = load_val;
      end else begin
         case (state_r)
            IDLE: begin
               count_nxt_s = count_r;
            end
            RUN: begin
               if (expire_s) begin
                  tc_nxt_s = 1'b1;
`ifdef AUTO_RELOAD_EN
                  // Reload on the expiry edge itself so tc repeats every
                  // reload-value cycles.
                  count_nxt_s = reload_r;
`else
                  count_nxt_s = CNT_ZERO;
`endif
               end else if (!pause && (count_r != CNT_ZERO)) begin
                  count_nxt_s = count_r - CNT_ONE;
               end else begin
                  count_nxt_s = count_r;
               end
            end
            DONE: begin
               if (start && (reload_r != CNT_ZERO)) begin
                  count_nxt_s = reload_r;
               end else begin
                  count_nxt_s = count_r;
               end
            end
            default: begin
               count_nxt_s = count_r;
            end
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r  <= CNT_ZERO;
         reload_r <= CNT_ZERO;
         tc_r     <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         count_r  <= count_nxt_s;
         reload_r <= reload_nxt_s;
         tc_r     <= tc_nxt_s;
         busy_r   <= busy_nxt_s;
         done_r   <= done_nxt_s;
      end
   end

   assign count = count_r;
   assign busy  = busy_r;
   assign tc    = tc_r;
   assign done  = done_r;

endmodule : down_counter_timer
